// File: rtl/mcp_adder_if.sv
// Operand/result handshake bundle for the multicycle-path adder.
// The master drives operands; the slave returns the sum and status.
interface mcp_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic [WIDTH:0]   sum;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, A, B, sub,
        input  in_ready, sum, out_valid, busy
    );

    modport slave (
        input  in_valid, A, B, sub,
        output in_ready, sum, out_valid, busy
    );
endinterface

// File: rtl/mcp_adder.sv
// Multicycle-path adder/subtractor: operands are registered on acceptance and the
// result is sampled MCP_CYCLES clocks later, timed by a down-counter.
module mcp_adder #(
    parameter int WIDTH      = 4,
    parameter int MCP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    mcp_adder_if.slave  bus
);
    localparam int CW = $clog2(MCP_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             reg_sub;
    logic [WIDTH:0]   sum_q;
    logic             out_valid_q;
    logic             ready;
    logic             busy;
    logic             take;
    logic             done;
    logic [WIDTH:0]   result;

    // reg_* are frozen for the whole WAIT window; this is the multicycle path.
    assign result = reg_sub ? ({1'b0, reg_a} - {1'b0, reg_b})
                            : ({1'b0, reg_a} + {1'b0, reg_b});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt   = state;
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    done = 1'b1;
                    nxt  = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign take = ready & bus.in_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_a       <= '0;
            reg_b       <= '0;
            reg_sub     <= 1'b0;
            cnt         <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= done;
            if (take) begin
                reg_a   <= bus.A;
                reg_b   <= bus.B;
                reg_sub <= bus.sub;
                cnt     <= CW'(MCP_CYCLES - 1);
            end else if (busy && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (done) begin
                sum_q <= result;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.busy      = busy;
    assign bus.sum       = sum_q;
    assign bus.out_valid = out_valid_q;
endmodule
